// File: rtl/dvp_capture_pack.sv
// DVP camera capture front-end: drops warm-up frames, gates capture on frame
// boundaries, packs sensor beats into pixels and tags them with X/Y and markers.
module dvp_capture_pack #(
    parameter int DATA_W         = 8,
    parameter int BYTES_PER_PIX  = 2,
    parameter int SKIP_FRAMES    = 10,
    parameter int CNT_W          = 12,
    parameter int VSYNC_ACT_HIGH = 1
) (
    input  logic                            PCLK,
    input  logic                            Rst,
    input  logic                            Vsync,
    input  logic                            Href,
    input  logic [DATA_W-1:0]               Data,
    input  logic                            Send_En,
    output logic [DATA_W*BYTES_PER_PIX-1:0] Pix_Data,
    output logic                            Pix_Valid,
    output logic                            Pix_Sof,
    output logic [CNT_W-1:0]                Pix_X,
    output logic [CNT_W-1:0]                Pix_Y,
    output logic                            Line_Done,
    output logic [CNT_W-1:0]                Line_Len,
    output logic                            Frame_Done,
    output logic [CNT_W-1:0]                Frame_Lines,
    output logic                            Err_Partial,
    output logic                            Capturing,
    output logic                            Cam_Rst_n,
    output logic                            Cam_Pwdn
);

    localparam int              PIX_W     = DATA_W * BYTES_PER_PIX;
    localparam int              PH_W      = 2;
    localparam logic [PH_W-1:0] LAST_PH   = PH_W'(BYTES_PER_PIX - 1);
    localparam logic [7:0]      SKIP      = 8'(SKIP_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Vsync level that marks the active (non-blanking) part of a frame
    localparam logic            VS_ACTIVE = (VSYNC_ACT_HIGH != 0) ? 1'b0 : 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic              s1_vsync_reg, s2_vsync_reg;
    logic              s1_href_reg, s2_href_reg;
    logic [DATA_W-1:0] s1_data_reg;

    logic       vs_act_s1, vs_act_s2;
    logic       sof, eof, href_fall;
    logic [7:0] skip_cnt_reg;
    logic       warm;
    logic       is_active, byte_take, pix_done;

    logic [PH_W-1:0]  phase_reg;
    logic [CNT_W-1:0] x_reg, y_reg;
    logic             first_pix_reg;
    logic             err_reg;
    logic [PIX_W-1:0] pix_word;

    logic             pk_valid_reg;
    logic [PIX_W-1:0] pk_data_reg;
    logic             pk_sof_reg;
    logic [CNT_W-1:0] pk_x_reg, pk_y_reg;
    logic             pk_line_done_reg;
    logic [CNT_W-1:0] pk_line_len_reg;
    logic             pk_frame_done_reg;
    logic [CNT_W-1:0] pk_frame_lines_reg;

    assign Cam_Rst_n = 1'b1;
    assign Cam_Pwdn  = 1'b0;
    assign Capturing = (state_reg == ACTIVE);

    // Sync regs reset to the active Vsync level so a reset inside a frame
    // cannot fabricate a frame start on the first cycle afterwards.
    always_ff @(posedge PCLK) begin
        if (Rst) begin
            s1_vsync_reg <= VS_ACTIVE;
            s2_vsync_reg <= VS_ACTIVE;
            s1_href_reg  <= 1'b0;
            s2_href_reg  <= 1'b0;
            s1_data_reg  <= '0;
        end else begin
            s1_vsync_reg <= Vsync;
            s2_vsync_reg <= s1_vsync_reg;
            s1_href_reg  <= Href;
            s2_href_reg  <= s1_href_reg;
            s1_data_reg  <= Data;
        end
    end

    assign vs_act_s1 = (s1_vsync_reg == VS_ACTIVE);
    assign vs_act_s2 = (s2_vsync_reg == VS_ACTIVE);
    assign sof       = vs_act_s1 & ~vs_act_s2;
    assign eof       = ~vs_act_s1 & vs_act_s2;
    assign href_fall = s2_href_reg & ~s1_href_reg;

    always_ff @(posedge PCLK) begin
        if (Rst) begin
            skip_cnt_reg <= '0;
        end else if (sof && (skip_cnt_reg != SKIP)) begin
            skip_cnt_reg <= skip_cnt_reg + 8'd1;
        end
    end

    assign warm = (skip_cnt_reg == SKIP);

    always_ff @(posedge PCLK) begin
        if (Rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (Send_En && warm) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (!Send_En) begin
                    state_next = IDLE;
                end else if (sof) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (eof && !Send_En) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign is_active = (state_reg == ACTIVE);
    assign byte_take = is_active & s1_href_reg;
    assign pix_done  = byte_take & (phase_reg == LAST_PH);

    // One lane per beat, first beat in the MSBs; the final beat is taken
    // straight from s1 so the pixel is complete on the cycle it arrives.
    for (genvar gi = 0; gi < BYTES_PER_PIX; gi++) begin : g_lane
        if (gi < BYTES_PER_PIX - 1) begin : g_held
            logic [DATA_W-1:0] lane_reg;
            always_ff @(posedge PCLK) begin
                if (Rst) begin
                    lane_reg <= '0;
                end else if (byte_take && (phase_reg == PH_W'(gi))) begin
                    lane_reg <= s1_data_reg;
                end
            end
            assign pix_word[PIX_W-1-gi*DATA_W -: DATA_W] = lane_reg;
        end else begin : g_last
            assign pix_word[DATA_W-1:0] = s1_data_reg;
        end
    end

    always_ff @(posedge PCLK) begin
        if (Rst) begin
            phase_reg          <= '0;
            x_reg              <= '0;
            y_reg              <= '0;
            first_pix_reg      <= 1'b0;
            err_reg            <= 1'b0;
            pk_valid_reg       <= 1'b0;
            pk_data_reg        <= '0;
            pk_sof_reg         <= 1'b0;
            pk_x_reg           <= '0;
            pk_y_reg           <= '0;
            pk_line_done_reg   <= 1'b0;
            pk_line_len_reg    <= '0;
            pk_frame_done_reg  <= 1'b0;
            pk_frame_lines_reg <= '0;
        end else begin
            pk_valid_reg      <= 1'b0;
            pk_line_done_reg  <= 1'b0;
            pk_frame_done_reg <= 1'b0;
            if (sof) begin
                phase_reg     <= '0;
                x_reg         <= '0;
                y_reg         <= '0;
                first_pix_reg <= 1'b1;
            end else if (is_active) begin
                if (pix_done) begin
                    phase_reg     <= '0;
                    pk_valid_reg  <= 1'b1;
                    pk_data_reg   <= pix_word;
                    pk_sof_reg    <= first_pix_reg;
                    pk_x_reg      <= x_reg;
                    pk_y_reg      <= y_reg;
                    first_pix_reg <= 1'b0;
                    x_reg         <= x_reg + CNT_ONE;
                end else if (byte_take) begin
                    phase_reg <= phase_reg + PH_W'(1);
                end else if (href_fall) begin
                    pk_line_done_reg <= 1'b1;
                    pk_line_len_reg  <= x_reg;
                    x_reg            <= '0;
                    y_reg            <= y_reg + CNT_ONE;
                    phase_reg        <= '0;
                    if (phase_reg != '0) begin
                        err_reg <= 1'b1;
                    end
                end
                if (eof) begin
                    pk_frame_done_reg  <= 1'b1;
                    pk_frame_lines_reg <= href_fall ? (y_reg + CNT_ONE) : y_reg;
                end
            end
        end
    end

    // Output register: gives the two-edge latency from sampling to strobe.
    always_ff @(posedge PCLK) begin
        if (Rst) begin
            Pix_Data    <= '0;
            Pix_Valid   <= 1'b0;
            Pix_Sof     <= 1'b0;
            Pix_X       <= '0;
            Pix_Y       <= '0;
            Line_Done   <= 1'b0;
            Line_Len    <= '0;
            Frame_Done  <= 1'b0;
            Frame_Lines <= '0;
            Err_Partial <= 1'b0;
        end else begin
            Pix_Valid   <= pk_valid_reg;
            Pix_Sof     <= pk_valid_reg & pk_sof_reg;
            Line_Done   <= pk_line_done_reg;
            Frame_Done  <= pk_frame_done_reg;
            Err_Partial <= err_reg;
            if (pk_valid_reg) begin
                Pix_Data <= pk_data_reg;
                Pix_X    <= pk_x_reg;
                Pix_Y    <= pk_y_reg;
            end
            if (pk_line_done_reg) begin
                Line_Len <= pk_line_len_reg;
            end
            if (pk_frame_done_reg) begin
                Frame_Lines <= pk_frame_lines_reg;
            end
        end
    end

endmodule
